alu_packet_ctrl: RTL and testbench
==================================

// Module: alu_packet_ctrl
// PURPOSE
//  Command sequencer between the UART AXI-stream byte ports and the ALU. Parses framed packets
//  received on the UART RX stream, runs the ALU over the 32-bit operands and streams results
//  back to the UART TX. Sits in the icebreaker top on the PLL clock domain.
//  Packet format: opcode, reserved, LEN[7:0], LEN[15:8], then LEN-4 payload bytes.
//  LEN counts the total packet bytes, header included.
// PARAMETERS
//  TIMEOUT_CYCLES  32'd3225600  idle cycles allowed between bytes mid-packet (100 ms @32.256MHz)
// PORTS
//  clk              in   1   PLL clock (PLLOUTGLOBAL); single clock domain
//  rst_n            in   1   asynchronous reset, active low
//  rx_tdata_i       in   8   byte from UART m_axis
//  rx_tvalid_i      in   1   RX byte valid
//  rx_tready_o      out  1   controller accepts RX byte
//  tx_tdata_o       out  8   byte to UART s_axis
//  tx_tvalid_o      out  1   TX byte valid
//  tx_tready_i      in   1   UART TX accepts byte
//  alu_op_o         out  2   0=ADD 1=MUL 2=DIV(unsigned)
//  alu_a_o/alu_b_o  out  32  accumulator / next operand
//  alu_valid_o      out  1   ALU request valid
//  alu_ready_i      in   1   ALU accepts request
//  alu_res_i        in   32  ALU result
//  alu_res_valid_i  in   1   one-cycle result strobe; at most one request outstanding
//  busy_o           out  1   high whenever state != HDR0
//  err_o            out  1   sticky framing error; cleared only by reset
// BEHAVIOUR
//  - Reset (async, any state): state=HDR0; all outputs 0. Counters, accumulator and any partial packet are discarded.
//  - Handshakes: an AXI beat transfers on valid&&ready. tvalid/tdata and alu_valid/a/b/op hold until
//    the transfer. rx_tready_o is high only in HDR0,HDR1,LEN0,LEN1,ECHO(when TX slot empty),OPND,DRAIN.
//  - FSM: HDR0->HDR1->LEN0->LEN1 advance one per accepted byte. HDR0 latches the opcode.
//    LEN1 computes rem=LEN-4 (16b). Then, in priority order:
//    LEN<4 -> err_o=1, HDR0 | rem==0 & opcode 0xEC -> HDR0 |
//    opcode 0xEC -> ECHO | opcode 0xA8/0x88/0x24 (ADD/MUL/DIV): if rem[1:0]!=0 -> err_o=1, DRAIN; else OPND |
//    any other opcode -> DRAIN.
//  - ECHO: each accepted byte goes to a 1-entry TX register; the next byte is not accepted until that
//    register drains. rem decrements per byte; rem==0 and TX register empty -> HDR0.
//  - OPND: shifts in 4 bytes little-endian per operand. First operand loads the accumulator directly,
//    with no ALU issue. Each later operand -> ISSUE (alu_valid_o=1, a=acc, b=operand).
//    On alu_ready_i -> WAIT. On alu_res_valid_i: acc<=alu_res_i; rem==0 -> SEND, else OPND.
//    If the first operand completes with rem==0 -> SEND. rem==0 at OPND entry -> SEND with acc=0.
//  - SEND: 4 bytes of acc, LSB first, one per TX transfer, then HDR0. Min latency:
//    last operand byte -> ISSUE is 1 cycle.
//  - DRAIN: accept and discard rem bytes; rx_tready_o=1; -> HDR0 at rem==0 (immediately if rem==0).
//  - Arithmetic: 32-bit wrap-around. DIV by zero is the ALU's business; the result is passed through.
//  - alu_res_valid_i outside WAIT is ignored. No RX bytes are accepted in ISSUE/WAIT/SEND.
// CONFIGURATION
//  ALU_CTRL_TIMEOUT_EN defined: a 32b counter clears on every accepted RX byte and counts cycles while
//   in HDR1,LEN0,LEN1,ECHO,OPND,DRAIN with rx_tready_o=1 and no byte.
//   Reaching TIMEOUT_CYCLES -> err_o=1, state=HDR0; a pending ECHO TX byte is still sent.
//  Not defined: no counter. A stalled packet waits indefinitely; TIMEOUT_CYCLES is unused.
// TESTING
//  1 RX EC 00 06 00 41 42 -> TX 41 42; busy_o low after; err_o=0.
//  2 RX A8 00 0C 00 05 00 00 00 07 00 00 00 -> ALU req op=0 a=5 b=7;
//    model returns 0000000C -> TX 0C 00 00 00.
//  3 Test 2 with tx_tready_i low 20 cycles per byte -> same 4 bytes; tdata stable while stalled.
//  4 RX 88 00 05 00 FF -> err_o=1, 1 byte drained, no TX, no ALU req.
//    A following echo packet still works.
//  5 rst_n pulsed low after 6 bytes of test 2 -> outputs 0 immediately;
//    a new test-1 packet gives correct echo.
//  6 ALU_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100: RX EC 00 then idle 100 cycles -> err_o=1, state HDR0.

Source files
------------

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: parses UART packets, sequences ALU ops over 32-bit operands, streams results to TX.
// Optional inter-byte timeout enabled by defining ALU_CTRL_TIMEOUT_EN.
module alu_packet_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3225600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    input  logic [31:0] alu_res_i,
    input  logic        alu_res_valid_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [3:0] {HDR0, HDR1, LEN0, LEN1, ECHO, OPND, ISSUE, WAIT, SEND, DRAIN} state_t;
    state_t      state_q, state_d;
    logic        live_q;
    logic [7:0]  opcode_q, opcode_d, len_lo_q, len_lo_d, tx_q, tx_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] acc_q, acc_d, opnd_q, opnd_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d, send_cnt_q, send_cnt_d;
    logic        first_q, first_d, tx_valid_q, tx_valid_d, err_q, err_d;
    logic        rx_acc, tx_fire, send_fire, is_arith, timeout;
    logic [15:0] len_full, rem_len, rem_dec;
    logic [31:0] opnd_full;
    always_comb begin
        rx_acc    = rx_tvalid_i && rx_tready_o;
        tx_fire   = tx_tvalid_o && tx_tready_i;
        send_fire = tx_fire && !tx_valid_q && state_q == SEND;
        len_full  = {rx_tdata_i, len_lo_q};
        rem_len   = len_full - 16'd4;
        rem_dec   = rem_q - 16'd1;
        opnd_full = {rx_tdata_i, opnd_q[31:8]};
        is_arith  = opcode_q inside {8'hA8, 8'h88, 8'h24};
    end
`ifdef ALU_CTRL_TIMEOUT_EN
    logic [31:0] to_q, to_d;
    logic        to_cnt, in_pkt;
    always_comb begin
        in_pkt  = state_q inside {HDR1, LEN0, LEN1, ECHO, OPND, DRAIN};
        to_cnt  = in_pkt && rx_tready_o && !rx_tvalid_i;
        timeout = to_cnt && (to_q + 32'd1 >= TIMEOUT_CYCLES);
        to_d    = (rx_acc || timeout || !in_pkt) ? 32'd0 : to_cnt ? to_q + 32'd1 : to_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR0;
            live_q     <= 1'b0;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            tx_q       <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            byte_cnt_q <= '0;
            send_cnt_q <= '0;
            first_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            tx_q       <= tx_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            byte_cnt_q <= byte_cnt_d;
            send_cnt_q <= send_cnt_d;
            first_q    <= first_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR0:  state_d = rx_acc ? HDR1 : HDR0;
            HDR1:  state_d = rx_acc ? LEN0 : HDR1;
            LEN0:  state_d = rx_acc ? LEN1 : LEN0;
            LEN1:  if (rx_acc)
                       state_d = len_full < 16'd4 ? HDR0 :
                                 opcode_q == 8'hEC ? (rem_len == 16'd0 ? HDR0 : ECHO) :
                                 is_arith ? (rem_len[1:0] != 2'd0 ? DRAIN : rem_len == 16'd0 ? SEND : OPND) :
                                 rem_len == 16'd0 ? HDR0 : DRAIN;
            ECHO:  state_d = (rem_q == 16'd0 && !tx_valid_q) ? HDR0 : ECHO;
            OPND:  if (rx_acc && byte_cnt_q == 2'd3)
                       state_d = !first_q ? ISSUE : rem_dec == 16'd0 ? SEND : OPND;
            ISSUE: state_d = alu_ready_i ? WAIT : ISSUE;
            WAIT:  if (alu_res_valid_i) state_d = rem_q == 16'd0 ? SEND : OPND;
            SEND:  state_d = (send_fire && send_cnt_q == 2'd3) ? HDR0 : SEND;
            DRAIN: state_d = (rem_q == 16'd0 || (rx_acc && rem_q == 16'd1)) ? HDR0 : DRAIN;
            default: state_d = HDR0;
        endcase
        if (timeout) state_d = HDR0;
    end
    always_comb begin
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        tx_d       = tx_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        byte_cnt_d = byte_cnt_q;
        send_cnt_d = send_cnt_q;
        first_d    = first_q;
        tx_valid_d = (tx_fire && tx_valid_q) ? 1'b0 : tx_valid_q;
        err_d      = err_q || timeout;
        if (rx_acc && state_q == HDR0) opcode_d = rx_tdata_i;
        if (rx_acc && state_q == LEN0) len_lo_d = rx_tdata_i;
        if (rx_acc && state_q == LEN1) begin
            rem_d      = rem_len;
            acc_d      = '0;
            first_d    = 1'b1;
            byte_cnt_d = '0;
            send_cnt_d = '0;
            err_d      = err_q || len_full < 16'd4 ||
                         (opcode_q != 8'hEC && is_arith && rem_len[1:0] != 2'd0);
        end
        if (rx_acc && state_q == ECHO) begin
            tx_d       = rx_tdata_i;
            tx_valid_d = 1'b1;
            rem_d      = rem_dec;
        end
        if (rx_acc && state_q == OPND) begin
            opnd_d     = opnd_full;
            rem_d      = rem_dec;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3 && first_q) begin
                acc_d   = opnd_full;
                first_d = 1'b0;
            end
        end
        if (rx_acc && state_q == DRAIN) rem_d = rem_dec;
        if (state_q == WAIT && alu_res_valid_i) acc_d = alu_res_i;
        if (send_fire) send_cnt_d = send_cnt_q + 2'd1;
    end
    always_comb begin
        rx_tready_o = live_q && (state_q inside {HDR0, HDR1, LEN0, LEN1, OPND, DRAIN} ||
                                 (state_q == ECHO && !tx_valid_q));
        tx_tvalid_o = tx_valid_q || state_q == SEND;
        tx_tdata_o  = tx_valid_q ? tx_q : acc_q[{send_cnt_q, 3'b000} +: 8];
        alu_valid_o = state_q == ISSUE;
        alu_op_o    = opcode_q == 8'h88 ? 2'd1 : opcode_q == 8'h24 ? 2'd2 : 2'd0;
        alu_a_o     = acc_q;
        alu_b_o     = opnd_q;
        busy_o      = state_q != HDR0;
        err_o       = err_q;
    end
endmodule

// File: tb/tb_alu_packet_ctrl.sv
// tb_alu_packet_ctrl: directed packet vectors with hand-computed results and a small ALU responder.
module tb_alu_packet_ctrl;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  rx_tdata_i = 0, tx_tdata_o;
    logic        rx_tvalid_i = 0, rx_tready_o, tx_tvalid_o, tx_tready_i = 1;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o, alu_res_i = 0;
    logic        alu_valid_o, alu_ready_i = 1, alu_res_valid_i = 0, busy_o, err_o;
    int          checks = 0, failures = 0;
    logic [7:0]  pkt[$], txq[$];
    int          req_n = 0, alu_cnt = 0, wait_cnt = 0, unstable = 0;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b, alu_pend;
    logic        stall_en = 0, hold_v = 0;
    logic [7:0]  hold_d;

    alu_packet_ctrl #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
        .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_valid_o(alu_valid_o),
        .alu_ready_i(alu_ready_i), .alu_res_i(alu_res_i), .alu_res_valid_i(alu_res_valid_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_tvalid_o && tx_tready_i) txq.push_back(tx_tdata_o);
        if (tx_tvalid_o && !tx_tready_i) begin
            if (hold_v && tx_tdata_o != hold_d) unstable++;
            hold_v = 1;
            hold_d = tx_tdata_o;
        end else hold_v = 0;
        if (alu_valid_o && alu_ready_i) begin
            req_n++;
            req_op = alu_op_o;
            req_a = alu_a_o;
            req_b = alu_b_o;
            alu_pend = alu_op_o == 2'd1 ? alu_a_o * alu_b_o :
                       alu_op_o == 2'd2 ? (alu_b_o != 0 ? alu_a_o / alu_b_o : 32'd0) : alu_a_o + alu_b_o;
            alu_cnt = 2;
        end
    end

    always @(negedge clk) begin
        alu_res_valid_i = 0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_res_valid_i = 1;
                alu_res_i = alu_pend;
            end
        end
        if (!stall_en) tx_tready_i = 1;
        else if (tx_tvalid_o && wait_cnt < 20) begin
            tx_tready_i = 0;
            wait_cnt++;
        end else begin
            tx_tready_i = tx_tvalid_o;
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int n;
        rx_tdata_i = b;
        rx_tvalid_i = 1;
        ok = 0;
        for (n = 0; n < 500; n++) begin
            ok = rx_tready_o;
            @(negedge clk);
            if (ok) break;
        end
        rx_tvalid_i = 0;
        if (!ok) check("rx_accept", 0, 1);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 1000 && (busy_o || tx_tvalid_o); n++) @(negedge clk);
        check(tag, {31'd0, busy_o}, 0);
    endtask

    task automatic check_tx(input string tag, input logic [31:0] exp);
        check({tag, "_cnt"}, txq.size(), 4);
        if (txq.size() == 4) check({tag, "_data"}, {txq[3], txq[2], txq[1], txq[0]}, exp);
        txq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_err", {31'd0, err_o}, 0);
        check("rst_rdy", {31'd0, rx_tready_o}, 0);
        check("rst_tx", {23'd0, tx_tvalid_o, tx_tdata_o}, 0);
        check("rst_alu", {31'd0, alu_valid_o}, 0);
        check("rst_acc", alu_a_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        txq.delete();
    endtask

    initial begin
        do_reset();
        check("idle_rdy", {31'd0, rx_tready_o}, 1);
        // echo
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        send_pkt();
        wait_idle("echo_idle");
        check("echo_cnt", txq.size(), 2);
        if (txq.size() == 2) check("echo_data", {16'd0, txq[0], txq[1]}, 32'h4142);
        check("echo_err", {31'd0, err_o}, 0);
        txq.delete();
        // ADD 5+7
        pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("add_idle");
        check("add_req_n", req_n, 1);
        check("add_req", {req_op, 30'd0}, 0);
        check("add_a", req_a, 5);
        check("add_b", req_b, 7);
        check_tx("add_tx", 32'h0000000C);
        // same with TX backpressure
        stall_en = 1;
        send_pkt();
        wait_idle("stall_idle");
        stall_en = 0;
        check_tx("stall_tx", 32'h0000000C);
        check("stall_stable", unstable, 0);
        // MUL 3*4*5
        pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("mul_idle");
        check("mul_req_n", req_n, 4);
        check("mul_op", {30'd0, req_op}, 1);
        check("mul_a", req_a, 32'h0C);
        check("mul_b", req_b, 5);
        check_tx("mul_tx", 32'h0000003C);
        // DIV 100/7
        pkt = '{8'h24, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("div_idle");
        check("div_op", {30'd0, req_op}, 2);
        check_tx("div_tx", 32'h0000000E);
        // ADD wrap FFFFFFFF+2
        pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("wrap_idle");
        check_tx("wrap_tx", 32'h00000001);
        // LEN=4 arithmetic: no operands, acc=0 sent, no ALU request
        pkt = '{8'hA8, 8'h00, 8'h04, 8'h00};
        send_pkt();
        wait_idle("len4_idle");
        check("len4_req_n", req_n, 6);
        check_tx("len4_tx", 32'h0);
        // unknown opcode drained silently
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        send_pkt();
        wait_idle("unk_idle");
        check("unk_tx", txq.size(), 0);
        check("unk_err", {31'd0, err_o}, 0);
        // misaligned MUL payload
        pkt = '{8'h88, 8'h00, 8'h05, 8'h00, 8'hFF};
        send_pkt();
        wait_idle("bad_idle");
        check("bad_err", {31'd0, err_o}, 1);
        check("bad_tx", txq.size(), 0);
        check("bad_req_n", req_n, 6);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt();
        wait_idle("bad_echo_idle");
        check("bad_echo_cnt", txq.size(), 1);
        if (txq.size() == 1) check("bad_echo_data", {24'd0, txq[0]}, 32'h5A);
        txq.delete();
        // reset mid-packet
        pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
        send_pkt();
        check("mid_busy", {31'd0, busy_o}, 1);
        do_reset();
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        send_pkt();
        wait_idle("post_rst_idle");
        check("post_rst_cnt", txq.size(), 2);
        if (txq.size() == 2) check("post_rst_data", {16'd0, txq[0], txq[1]}, 32'h4142);
        txq.delete();
        // stalled packet mid-header
        pkt = '{8'hEC, 8'h00};
        send_pkt();
        repeat (110) @(negedge clk);
`ifdef ALU_CTRL_TIMEOUT_EN
        check("to_err", {31'd0, err_o}, 1);
        check("to_busy", {31'd0, busy_o}, 0);
`else
        check("stall_err", {31'd0, err_o}, 0);
        check("stall_busy", {31'd0, busy_o}, 1);
`endif
        do_reset();
        // LEN<4
        pkt = '{8'hA8, 8'h00, 8'h03, 8'h00};
        send_pkt();
        wait_idle("short_idle");
        check("short_err", {31'd0, err_o}, 1);
        check("short_tx", txq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
